dram_byte_responder: RTL

- Byte-wide RAM responder on the far side of the data-memory shim's RAM interface.
- Decodes byte read/write commands from dshim (RAMuse/RAMaddr/RAMread/RAMwrite/data_to_RAM) and returns data_from_RAM with fixed one-cycle latency.
- Also serves a lower-priority byte fetch port for the instruction side, which is stalled while dshim owns the RAM.
- Holds the byte array and flags illegal accesses.

---
 rtl/dram_byte_responder.sv | 101 ++++++++++
 1 files changed

// File: rtl/dram_byte_responder.sv
// Byte-wide RAM responder behind the data-memory shim.
// dshim has priority over a byte fetch port. Both read paths have a fixed one-cycle latency.
module dram_byte_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RAMuse,
  input  logic [ADDR_W-1:0] RAMaddr,
  input  logic [7:0]        data_to_RAM,
  input  logic              RAMwrite,
  input  logic              RAMread,
  output logic [7:0]        data_from_RAM,
  output logic              d_rvalid,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [7:0]        idata,
  output logic              ivalid,
  output logic              istall,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DACC,
    ARB_IACC
  } arb_e;

  arb_e                  arb_c;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] d_idx;
  logic [DEPTH_LOG2-1:0] i_idx;
  logic                  d_in_range;
  logic                  i_in_range;
  logic                  mem_we;
  logic                  d_rd;
  logic                  i_rd;
  logic                  illegal;

  // Upper address bits must be zero; addresses are never truncated or wrapped.
  assign d_in_range = (RAMaddr[ADDR_W-1:DEPTH_LOG2] == '0);
  assign i_in_range = (iaddr[ADDR_W-1:DEPTH_LOG2] == '0);
  assign d_idx      = RAMaddr[DEPTH_LOG2-1:0];
  assign i_idx      = iaddr[DEPTH_LOG2-1:0];

  // Arbitration is re-evaluated every cycle, so RAMuse gates the fetch port cycle by cycle.
  always_comb begin
    arb_c = ARB_IDLE;
    if (RAMuse && (RAMread || RAMwrite)) begin
      arb_c = ARB_DACC;
    end else if (!RAMuse && ireq) begin
      arb_c = ARB_IACC;
    end
  end

  assign istall = ireq & RAMuse;

  // A write always wins a simultaneous read strobe; out-of-range writes are dropped.
  assign mem_we = (arb_c == ARB_DACC) && RAMwrite && d_in_range;
  assign d_rd   = (arb_c == ARB_DACC) && RAMread && !RAMwrite;
  assign i_rd   = (arb_c == ARB_IACC);

  assign illegal = (!RAMuse && (RAMread || RAMwrite))
                || ((arb_c == ARB_DACC) && RAMread && RAMwrite)
                || ((arb_c == ARB_DACC) && !d_in_range)
                || ((arb_c == ARB_IACC) && !i_in_range);

  // Byte array: deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[d_idx] <= data_to_RAM;
    end
  end

  // Registered read returns, valid pulses and the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_from_RAM <= 8'h00;
      d_rvalid      <= 1'b0;
      idata         <= 8'h00;
      ivalid        <= 1'b0;
      err           <= 1'b0;
    end else begin
      d_rvalid <= d_rd;
      ivalid   <= i_rd;
      if (d_rd) begin
        data_from_RAM <= d_in_range ? mem[d_idx] : 8'h00;
      end
      if (i_rd) begin
        idata <= i_in_range ? mem[i_idx] : 8'h00;
      end
      if (illegal) begin
        err <= 1'b1;
      end
    end
  end

endmodule
